crc_lut_engine: RTL
===================

CRC_LUT_ENGINE -- requirements
Module: crc_lut_engine

Interface
REQ-001 SHALL have parameter INIT, default 32'hFFFFFFFF: CRC seed at frame start.
REQ-002 SHALL have parameter XOROUT, default 32'hFFFFFFFF: final XOR applied to the result.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  engine accepts the word this cycle.
REQ-007 in_data  input  32  data word; byte 3 = in_data[31:24] is consumed first.
REQ-008 in_sof  input  1  word is the first of a frame.
REQ-009 in_eof  input  1  word is the last of a frame.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_crc  output  32  final CRC, crc_reg ^ XOROUT.
REQ-013 out_words  output  16  words in the frame, saturating.
REQ-014 tN_addr  output  32 (N=1..4)  lookup address to slice table crctab_evN; [31:8] tied 0.
REQ-015 tN_rdata  input  32 (N=1..4)  combinational (same-cycle) table read data.

Function
REQ-016 Accept = in_valid && in_ready; SHALL NOT change state on cycles without an accept or an output handshake.
REQ-017 seed SHALL be INIT when state is IDLE or DONE, or when in_sof=1; otherwise crc_reg.
REQ-018 x = seed ^ in_data; t4_addr[7:0]=x[31:24], t3_addr[7:0]=x[23:16], t2_addr[7:0]=x[15:8], t1_addr[7:0]=x[7:0].
REQ-019 On accept, crc_reg SHALL load t4_rdata ^ t3_rdata ^ t2_rdata ^ t1_rdata; throughput one word per cycle, single-cycle feedback loop.
REQ-020 FSM states: IDLE, ACCUM, DONE.
REQ-021 IDLE: in_ready=1. On accept, eof=1 -> DONE, else -> ACCUM. in_sof is ignored; a frame is implied.
REQ-022 ACCUM: in_ready=1. On accept, eof=1 -> DONE, else stay in ACCUM.
REQ-023 ACCUM with accept and in_sof=1: restart the frame; seed=INIT; word count restarts at 1; prior partial frame is discarded without any output.
REQ-024 DONE: out_valid=1, and out_crc and out_words SHALL stay stable until out_ready.
REQ-025 DONE: in_ready = out_ready.
- out_ready=1 with no accept -> IDLE.
- out_ready=1 with accept -> new frame from INIT; next state is DONE if eof=1, else ACCUM.
REQ-026 Word counter: set to 1 on the first word of a frame, +1 per further accepted word, saturates at 16'hFFFF.
REQ-027 out_words SHALL reflect the counter including the eof word.
REQ-028 A word with sof=1 and eof=1 SHALL form a complete one-word frame.
REQ-029 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-030 out_crc SHALL be registered state XORed with a constant, with no combinational path from in_* to out_*.

Reset
REQ-031 On rst: state=IDLE, crc_reg=INIT, counter=0, out_valid=0.
REQ-032 On rst: out_crc=INIT^XOROUT, out_words=0, in_ready=0 while rst is asserted.
REQ-033 rst asserted mid-frame or in DONE SHALL discard the frame and the pending result; no out_valid pulse follows.
REQ-034 After rst deasserts, in_ready=1 from the first clock edge.

Verification
REQ-035 INIT=0, XOROUT=0: one word 0x01000000 with sof+eof -> next cycle out_valid=1, out_crc=0x490d678d, out_words=1.
REQ-036 INIT=0, XOROUT=0: one word 0xFF000000 with sof+eof -> out_crc=0x31e32653.
REQ-037 INIT=0, XOROUT=0: frame {0x01000000 sof, 0x490d678d eof} on back-to-back cycles -> out_crc=0x00000000, out_words=2.
REQ-038 INIT=0, default XOROUT: word 0x00000000 with sof+eof, out_ready=0 for 5 cycles -> out_crc=0xFFFFFFFF held, in_ready=0 throughout; then out_ready=1 with a new sof word -> result consumed and new word accepted in the same cycle.
REQ-039 sof mid-frame: 3 words, then a sof+eof word 0x01000000 (INIT=0, XOROUT=0) -> single result out_crc=0x490d678d, out_words=1.
REQ-040 rst pulse while in ACCUM and again while in DONE -> out_valid=0, out_words=0, in_ready=1 after release; a following frame computes correctly.

Source files
------------

// File: rtl/crc_lut_engine.sv
// crc_lut_engine: word-wide CRC over four external byte-slice tables, one word per cycle, framed result with handshake
module crc_lut_engine #(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_crc,
  output logic [15:0] out_words,
  output logic [31:0] t1_addr,
  output logic [31:0] t2_addr,
  output logic [31:0] t3_addr,
  output logic [31:0] t4_addr,
  input  logic [31:0] t1_rdata,
  input  logic [31:0] t2_rdata,
  input  logic [31:0] t3_rdata,
  input  logic [31:0] t4_rdata
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_crc;
  logic [15:0] r_cnt;
  logic        r_valid;
  logic        w_acc;
  logic        w_new;
  logic [31:0] w_x;
  // a pending result blocks input until downstream takes it, so both can happen in one cycle
  assign in_ready  = !rst && (r_state != DONE || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_new     = r_state != ACCUM || in_sof;
  assign w_x       = (w_new ? INIT : r_crc) ^ in_data;
  assign t4_addr   = {24'd0, w_x[31:24]};
  assign t3_addr   = {24'd0, w_x[23:16]};
  assign t2_addr   = {24'd0, w_x[15:8]};
  assign t1_addr   = {24'd0, w_x[7:0]};
  assign out_valid = r_valid;
  assign out_crc   = r_crc ^ XOROUT;
  assign out_words = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_crc   <= INIT;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_state <= in_eof ? DONE : ACCUM;
      r_valid <= in_eof;
      r_crc   <= t4_rdata ^ t3_rdata ^ t2_rdata ^ t1_rdata;
      r_cnt   <= w_new ? 16'd1 : (&r_cnt ? r_cnt : r_cnt + 16'd1);
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end
  end
endmodule
